exe_stage_mc: RTL
=================

Name: exe_stage_mc

Overview:
- Parametrised, multicycle execute stage for the MIPS multicycle core.
- Sits between the ID/EXE and EXE/MEM pipeline registers.
- Computes the ALU result, the branch target (PC + val2) and the branch decision.
- Adds iterative unsigned multiply, divide and remainder.
- Uses a valid/ready handshake on both sides and a registered output, so it can stall the pipeline.

Parameters:
- WIDTH, 32: datapath width in bits (val1, val2, val_src2, PC, results); must be >= 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage can accept a bundle.
- EXE_CMD  in  4  operation select.
- val1  in  WIDTH  operand A.
- val2  in  WIDTH  operand B / immediate / shifted branch offset.
- val_src2  in  WIDTH  rt register value for condition check.
- Br_type  in  2  00 none, 01 BEZ (val1==0), 10 BNE (val1!=val_src2), 11 JMP (always).
- PC  in  WIDTH  PC+4 of the instruction.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts bundle.
- ALU_result  out  WIDTH  registered result.
- Br_Addr  out  WIDTH  registered PC + val2 (mod 2^WIDTH).
- Br_taken  out  1  registered branch decision.
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, busy=0, ALU_result=0, Br_Addr=0, Br_taken=0, counter=0. in_ready=1 after reset.
- A reset mid-iteration abandons the operation; no bundle is emitted.
- A transfer occurs on a rising edge with in_valid & in_ready. Inputs are sampled only at that edge.
- in_ready = (state==IDLE) & (!out_valid | out_ready). A new bundle may be accepted in the same cycle the previous one is consumed.
- EXE_CMD encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL (val1 << val2[log2 WIDTH-1:0]), 1001 SRA, 1010 SRL.
  - 1011 SLT (signed val1<val2 -> 1 else 0).
  - 1100 MULU (low WIDTH bits of val1*val2), 1101 DIVU (quotient), 1110 REMU (remainder).
  - 0001, 0011, 1111: result 0, no error flag.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- Single-cycle ops (all except 1100-1110): result, Br_Addr and Br_taken are registered at the accept edge. out_valid=1 on the next cycle, so latency is 1.
- Iterative ops, FSM IDLE -> ITER -> IDLE:
  - At accept: latch operands, Br_Addr and Br_taken; counter=0; busy=1; state=ITER.
  - ITER, MULU: shift-add, one multiplier bit per cycle, LSB first.
  - ITER, DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
  - Counter increments each cycle. On the cycle counter==WIDTH-1, the final value is written to ALU_result, out_valid=1, busy=0 and state=IDLE.
  - Latency is WIDTH cycles from accept to out_valid.
- Divide by zero: DIVU returns all-ones; REMU returns val1. The full WIDTH cycles are still taken.
- Output hold: while out_valid & !out_ready, all outputs hold stable and no new bundle is accepted.
- out_valid clears on out_ready unless a new single-cycle result is loaded in the same edge.
- Br_type is evaluated combinationally from the latched operands at the accept edge, independent of EXE_CMD. Br_taken is meaningful only while out_valid=1.
- in_valid while busy: ignored (in_ready=0); upstream must hold its bundle.

Test Plan:
- Reset mid-MULU (assert rst_n=0 at iteration 10) -> all outputs 0 immediately, in_ready=1 after release, no out_valid ever seen for that op.
- ADD val1=0xFFFFFFFF, val2=1, out_ready=1 -> next cycle out_valid=1, ALU_result=0x00000000. Back-to-back SUB 5-7 accepted the same cycle -> ALU_result=0xFFFFFFFE on the following cycle.
- BNE val1=3, val_src2=4, PC=0x100, val2=0x20 -> Br_taken=1, Br_Addr=0x120. Repeat with val_src2=3 -> Br_taken=0. JMP -> Br_taken=1.
- MULU 0x0001_0003 * 0x0000_0005 -> in_ready=0 and busy=1 for 32 cycles; out_valid on cycle 32 after accept, ALU_result=0x0005_000F.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Backpressure: out_ready=0 for 5 cycles after a SLT(-1,1) result -> ALU_result=1 held stable, in_ready=0 throughout. out_ready=1 -> transfer completes, next bundle accepted that edge.

Source files
------------

// File: rtl/exe_stage_mc_if.sv
// Handshake bundle between ID/EXE and EXE/MEM around the multicycle execute stage.
// The master side is upstream/downstream logic; the slave side is the execute stage.
interface exe_stage_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       EXE_CMD;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] val_src2;
    logic [1:0]       Br_type;
    logic [WIDTH-1:0] PC;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_result;
    logic [WIDTH-1:0] Br_Addr;
    logic             Br_taken;
    logic             busy;

    modport master (
        output in_valid, EXE_CMD, val1, val2, val_src2, Br_type, PC, out_ready,
        input  in_ready, out_valid, ALU_result, Br_Addr, Br_taken, busy
    );

    modport slave (
        input  in_valid, EXE_CMD, val1, val2, val_src2, Br_type, PC, out_ready,
        output in_ready, out_valid, ALU_result, Br_Addr, Br_taken, busy
    );
endinterface

// File: rtl/exe_stage_mc.sv
// Multicycle MIPS execute stage: single-cycle ALU/branch ops plus iterative
// unsigned multiply (shift-add) and divide/remainder (restoring), with a registered output.
module exe_stage_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    exe_stage_mc_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, ITER} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM} iter_op_t;

    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [SH_W-1:0]         sh;
        logic [WIDTH-1:0]        res;
        a_s = a;
        b_s = b;
        sh  = b[SH_W-1:0];
        case (cmd)
            4'b0000: res = a + b;
            4'b0010: res = a - b;
            4'b0100: res = a & b;
            4'b0101: res = a | b;
            4'b0110: res = ~(a | b);
            4'b0111: res = a ^ b;
            4'b1000: res = a << sh;
            4'b1001: res = a_s >>> sh;
            4'b1010: res = a >> sh;
            4'b1011: res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic br_decide(
        input logic [1:0]       bt,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] src2
    );
        logic taken;
        case (bt)
            2'b01:   taken = (a == '0);
            2'b10:   taken = (a != src2);
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    state_t           state;
    iter_op_t         iter_op;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_r;
    logic             busy_r;
    logic             br_taken_r;
    logic [WIDTH-1:0] alu_result_r;
    logic [WIDTH-1:0] br_addr_r;

    // Shared iteration registers: acc is the partial product or partial remainder,
    // opa the multiplier or the dividend/quotient shifter, opb the multiplicand or divisor.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic             accept;
    logic             is_iter;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] iter_final;

    assign bus.in_ready   = (state == IDLE) && (!out_valid_r || bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign is_iter        = bus.EXE_CMD inside {4'b1100, 4'b1101, 4'b1110};

    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_r;
    assign bus.ALU_result = alu_result_r;
    assign bus.Br_Addr    = br_addr_r;
    assign bus.Br_taken   = br_taken_r;

    // A zero divisor makes every trial subtraction succeed, which naturally yields an
    // all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        mul_sum = acc[WIDTH-1:0] + (opa[0] ? opb : '0);
        r_sh    = {acc[WIDTH-1:0], opa[WIDTH-1]};
        q_bit   = (r_sh >= {1'b0, opb});
        r_next  = q_bit ? (r_sh - {1'b0, opb}) : r_sh;
        q_next  = {opa[WIDTH-2:0], q_bit};
        case (iter_op)
            OP_MUL:  iter_final = mul_sum;
            OP_DIV:  iter_final = q_next;
            default: iter_final = r_next[WIDTH-1:0];
        endcase
    end

    // Control and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            iter_op      <= OP_MUL;
            cnt          <= '0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            br_taken_r   <= 1'b0;
            alu_result_r <= '0;
            br_addr_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                    if (accept) begin
                        br_addr_r  <= bus.PC + bus.val2;
                        br_taken_r <= br_decide(bus.Br_type, bus.val1, bus.val_src2);
                        if (is_iter) begin
                            state  <= ITER;
                            busy_r <= 1'b1;
                            cnt    <= '0;
                            case (bus.EXE_CMD)
                                4'b1100: iter_op <= OP_MUL;
                                4'b1101: iter_op <= OP_DIV;
                                default: iter_op <= OP_REM;
                            endcase
                        end else begin
                            alu_result_r <= alu_single(bus.EXE_CMD, bus.val1, bus.val2);
                            out_valid_r  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        alu_result_r <= iter_final;
                        out_valid_r  <= 1'b1;
                        busy_r       <= 1'b0;
                        state        <= IDLE;
                        cnt          <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Iteration datapath; no reset needed since state gates every use
    always_ff @(posedge clk) begin
        if (accept && is_iter) begin
            acc <= '0;
            if (bus.EXE_CMD == 4'b1100) begin
                opa <= bus.val2;
                opb <= bus.val1;
            end else begin
                opa <= bus.val1;
                opb <= bus.val2;
            end
        end else if (state == ITER) begin
            if (iter_op == OP_MUL) begin
                acc <= {1'b0, mul_sum};
                opa <= opa >> 1;
                opb <= opb << 1;
            end else begin
                acc <= r_next;
                opa <= q_next;
            end
        end
    end

endmodule
